// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: states, opcodes,
// ALU op codes, IR field positions and the opcode-to-ALU-op table.
package cpu_defs_pkg;

  localparam int NUM_REGS = 16;
  localparam int OPW      = 5;
  localparam int IR_W     = 32;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT_S
  } state_t;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00010;
  localparam opcode_t OP_SUB  = 5'b00011;
  localparam opcode_t OP_AND  = 5'b00100;
  localparam opcode_t OP_OR   = 5'b00101;
  localparam opcode_t OP_SHR  = 5'b00110;
  localparam opcode_t OP_SHL  = 5'b00111;
  localparam opcode_t OP_ROR  = 5'b01000;
  localparam opcode_t OP_ROL  = 5'b01001;
  localparam opcode_t OP_ADDI = 5'b01010;
  localparam opcode_t OP_ANDI = 5'b01011;
  localparam opcode_t OP_ORI  = 5'b01100;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SHR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_ROR = 5'd6;
  localparam logic [4:0] ALU_ROL = 5'd7;
  localparam logic [4:0] ALU_MUL = 5'd8;
  localparam logic [4:0] ALU_DIV = 5'd9;
  localparam logic [4:0] ALU_NEG = 5'd10;
  localparam logic [4:0] ALU_NOT = 5'd11;

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] alu_ctrl(input opcode_t op);
    case (op)
      OP_ADD, OP_ADDI: alu_ctrl = ALU_ADD;
      OP_SUB:          alu_ctrl = ALU_SUB;
      OP_AND, OP_ANDI: alu_ctrl = ALU_AND;
      OP_OR,  OP_ORI:  alu_ctrl = ALU_OR;
      OP_SHR:          alu_ctrl = ALU_SHR;
      OP_SHL:          alu_ctrl = ALU_SHL;
      OP_ROR:          alu_ctrl = ALU_ROR;
      OP_ROL:          alu_ctrl = ALU_ROL;
      OP_MUL:          alu_ctrl = ALU_MUL;
      OP_DIV:          alu_ctrl = ALU_DIV;
      OP_NEG:          alu_ctrl = ALU_NEG;
      OP_NOT:          alu_ctrl = ALU_NOT;
      default:         alu_ctrl = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register select decoder with enable; all zeros when disabled.
module reg_sel_decoder
  import cpu_defs_pkg::*;
(
  input  logic                en,
  input  logic [3:0]          sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute control FSM for the Mini-SRC datapath.
// Build option ILLEGAL_TRAP_EN: undefined opcodes halt and raise illegal_op.
//
// state  | meaning
// IDLE   | stopped, all strobes low, waits for run
// T0     | PC -> MAR, PC+1 -> Z
// T1     | memory read; waits for mem_ready, then Zlow -> PC
// T2     | MDR -> IR; NOP/undefined finish here, HALT leaves to HALT_S
// T3..T5 | operand fetch, ALU operation, write-back (Ra or LO)
// T6     | MUL/DIV only: Zhigh -> HI
// HALT_S | halted until clear
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                PCin,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                LOin,
  output logic                Coutout,
  output logic [4:0]          ALU_Control,
  output logic                instr_done,
  output logic                halted
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_t  state;
  opcode_t opcode;
  logic [3:0] ra, rb, rc;
  logic is_alu, is_imm, is_unary, is_muldiv, is_nop, is_halt, is_illegal;
  logic is_exec, trap_now;
  logic       dec_en, dec_to_in;
  logic [3:0] dec_sel;
  logic [NUM_REGS-1:0] dec_onehot;
  logic unused_ir;

  assign opcode    = ir[OP_MSB:OP_LSB];
  assign ra        = ir[RA_MSB:RA_LSB];
  assign rb        = ir[RB_MSB:RB_LSB];
  assign rc        = ir[RC_MSB:RC_LSB];
  assign unused_ir = ^ir[RC_LSB-1:0];

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic illegal_q;

  always_ff @(posedge clock) begin
    if (!clear)                        illegal_q <= 1'b0;
    else if (state == T2 && is_illegal) illegal_q <= 1'b1;
  end

  assign illegal_op = halted & illegal_q;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always_comb begin
    is_alu     = 1'b0;
    is_imm     = 1'b0;
    is_unary   = 1'b0;
    is_muldiv  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: is_alu    = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:       is_imm    = 1'b1;
      OP_NEG, OP_NOT:                 is_unary  = 1'b1;
      OP_MUL, OP_DIV:                 is_muldiv = 1'b1;
      OP_NOP:                         is_nop    = 1'b1;
      OP_HALT:                        is_halt   = 1'b1;
      default:                        is_illegal = 1'b1;
    endcase
  end

  assign is_exec  = is_alu | is_imm | is_unary | is_muldiv;
  assign trap_now = is_halt | (TRAP_EN & is_illegal);

  // Finishing steps return to fetch only while run is held; run never aborts.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   if (run) state <= T0;
        T0:     state <= T1;
        T1:     if (mem_ready) state <= T2;
        T2: begin
          if (is_exec)       state <= T3;
          else if (trap_now) state <= HALT_S;
          else               state <= run ? T0 : IDLE;
        end
        T3:     state <= T4;
        T4:     state <= T5;
        T5:     state <= is_muldiv ? T6 : (run ? T0 : IDLE);
        T6:     state <= run ? T0 : IDLE;
        HALT_S: state <= HALT_S;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCin        = 1'b0;
    PCout       = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    Read        = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    Zhighout    = 1'b0;
    Zlowout     = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Coutout     = 1'b0;
    ALU_Control = ALU_ADD;
    instr_done  = 1'b0;
    halted      = 1'b0;
    dec_en      = 1'b0;
    dec_to_in   = 1'b0;
    dec_sel     = 4'd0;
    if (clear) begin
      case (state)
        T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
        T1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (mem_ready) begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
          end
        end
        T2: begin
          MDRout     = 1'b1;
          IRin       = 1'b1;
          instr_done = ~is_exec & ~trap_now;
        end
        T3: begin
          Yin     = 1'b1;
          dec_en  = 1'b1;
          dec_sel = is_muldiv ? ra : rb;
        end
        T4: begin
          Zin         = 1'b1;
          ALU_Control = alu_ctrl(opcode);
          if (is_imm) begin
            Coutout = 1'b1;
          end else begin
            dec_en  = 1'b1;
            dec_sel = is_alu ? rc : rb;
          end
        end
        T5: begin
          Zlowout = 1'b1;
          if (is_muldiv) begin
            LOin = 1'b1;
          end else begin
            dec_en     = 1'b1;
            dec_to_in  = 1'b1;
            dec_sel    = ra;
            instr_done = 1'b1;
          end
        end
        T6: begin
          Zhighout   = 1'b1;
          HIin       = 1'b1;
          instr_done = 1'b1;
        end
        HALT_S: halted = 1'b1;
        default: ;
      endcase
    end
  end

  reg_sel_decoder u_reg_sel (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (dec_onehot)
  );

  // One decoder serves both buses; a step never drives a register in and out together.
  assign reg_in  = dec_to_in ? dec_onehot : '0;
  assign reg_out = dec_to_in ? '0 : dec_onehot;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a cycle-by-cycle expected-strobe queue built
// from instruction semantics, checked every cycle, plus literal spot checks.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_in, reg_out;
  logic PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin;
  logic Zhighout, Zlowout, HIin, LOin, Coutout;
  logic [4:0] ALU_Control;
  logic instr_done, halted;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_op;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .reg_in(reg_in), .reg_out(reg_out),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
    .Coutout(Coutout), .ALU_Control(ALU_Control), .instr_done(instr_done),
    .halted(halted)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, incpc, marin, mdrin, mdrout, rd, irin, yin, zin;
    logic zhi, zlo, hiin, loin, cout;
    logic [4:0] alu;
    logic done, halt, ill;
  } outs_t;

  localparam int K_NOP = 0, K_ALU = 1, K_IMM = 2, K_UN = 3, K_MD = 4, K_HALT = 5, K_ILL = 6;

  outs_t exp_q[$];
  int    passed = 0;
  int    total  = 0;
  string cur_tag = "reset";

  function automatic outs_t sample();
    outs_t a;
    a.rin = reg_in;  a.rout = reg_out;
    a.pcin = PCin;   a.pcout = PCout;   a.incpc = IncPC; a.marin = MARin;
    a.mdrin = MDRin; a.mdrout = MDRout; a.rd = Read;     a.irin = IRin;
    a.yin = Yin;     a.zin = Zin;       a.zhi = Zhighout; a.zlo = Zlowout;
    a.hiin = HIin;   a.loin = LOin;     a.cout = Coutout; a.alu = ALU_Control;
    a.done = instr_done; a.halt = halted;
`ifdef ILLEGAL_TRAP_EN
    a.ill = illegal_op;
`else
    a.ill = 1'b0;
`endif
    return a;
  endfunction

  always @(negedge clock) begin
    outs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      total++;
      if (a !== e) $display("FAIL %s strobes actual=%h required=%h", cur_tag, a, e);
      else passed++;
    end
  end

  // Instruction class from the opcode number.
  function automatic int kind_of(input logic [31:0] w);
    int op;
    op = int'(w >> 27);
    if (op >= 2 && op <= 9)   return K_ALU;
    if (op >= 10 && op <= 12) return K_IMM;
    if (op == 17 || op == 18) return K_UN;
    if (op == 15 || op == 16) return K_MD;
    if (op == 27)             return K_HALT;
    if (op == 26)             return K_NOP;
    return TRAP ? K_ILL : K_NOP;
  endfunction

  // ALU code: R-type ops are numbered from ADD=2; MUL..NOT sit at opcode-7.
  function automatic int alu_of(input logic [31:0] w);
    int op;
    op = int'(w >> 27);
    case (kind_of(w))
      K_ALU:   return op - 2;
      K_IMM:   return (op == 10) ? 0 : ((op == 11) ? 2 : 3);
      default: return op - 7;
    endcase
  endfunction

  function automatic outs_t fetch_exp(input int t, input bit mr);
    outs_t e = '0;
    if (t == 0) begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; end
    if (t == 1) begin e.rd = 1; e.mdrin = 1; e.zlo = mr; e.pcin = mr; end
    if (t == 2) begin e.mdrout = 1; e.irin = 1; end
    return e;
  endfunction

  function automatic outs_t exec_exp(input logic [31:0] w, input int t);
    outs_t e = '0;
    int k, ra, rb, rc;
    k  = kind_of(w);
    ra = int'((w >> 23) & 32'hF);
    rb = int'((w >> 19) & 32'hF);
    rc = int'((w >> 15) & 32'hF);
    case (t)
      3: begin e.yin = 1; e.rout = 16'(1 << ((k == K_MD) ? ra : rb)); end
      4: begin
        e.zin = 1;
        e.alu = 5'(alu_of(w));
        if (k == K_IMM) e.cout = 1;
        else e.rout = 16'(1 << ((k == K_ALU) ? rc : rb));
      end
      5: begin
        e.zlo = 1;
        if (k == K_MD) e.loin = 1;
        else begin e.rin = 16'(1 << ra); e.done = 1; end
      end
      default: begin e.zhi = 1; e.hiin = 1; e.done = 1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
    else passed++;
  endtask

  task automatic step(input outs_t e);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input outs_t e);
    step(e);
    tick();
  endtask

  task automatic hook(input string tag, input int ph);
    if (tag == "add") begin
      if (ph == 3) begin chk("add_t3_rout", 32'(reg_out), 32'h0020); chk("add_t3_yin", 32'(Yin), 1); end
      if (ph == 4) begin chk("add_t4_rout", 32'(reg_out), 32'h0040); chk("add_t4_alu", 32'(ALU_Control), 0); chk("add_t4_zin", 32'(Zin), 1); end
      if (ph == 5) begin chk("add_t5_rin", 32'(reg_in), 32'h0004); chk("add_t5_zlo", 32'(Zlowout), 1); chk("add_t5_done", 32'(instr_done), 1); end
    end
    if (tag == "sub_wait") begin
      if (ph == 100) begin chk("wait_pcin_low", 32'(PCin), 0); chk("wait_read", 32'(Read), 1); end
      if (ph == 1)   begin chk("wait_pcin_last", 32'(PCin), 1); chk("wait_zlo_last", 32'(Zlowout), 1); end
      if (ph == 2)   chk("wait_t2_irin", 32'(IRin), 1);
    end
    if (tag == "mul") begin
      if (ph == 3) chk("mul_t3_rout", 32'(reg_out), 32'h0008);
      if (ph == 4) begin chk("mul_t4_rout", 32'(reg_out), 32'h0010); chk("mul_t4_alu", 32'(ALU_Control), 8); end
      if (ph == 5) chk("mul_t5_loin", 32'(LOin), 1);
      if (ph == 6) chk("mul_t6_hi_done", 32'({Zhighout, HIin, instr_done}), 32'h7);
    end
    if (tag == "and_r0" && ph == 5) chk("r0_dest_rin", 32'(reg_in), 32'h0001);
    if (tag == "add_clr" && ph == 4) chk("clr_t4_zero", 32'({reg_in, reg_out, Zin}), 0);
  endtask

  task automatic cych(input outs_t e, input int ph);
    step(e);
    hook(cur_tag, ph);
    tick();
  endtask

  // Starts in T0 with run already high.
  task automatic run_instr(input logic [31:0] w, input int waits, input bit drop_run,
                           input int abort_at, input string tag);
    int    k;
    int    last;
    outs_t e;
    k    = kind_of(w);
    last = (k == K_MD) ? 6 : 5;
    cur_tag = tag;
    ir = w;
    cych(fetch_exp(0, 0), 0);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 0;
      cych(fetch_exp(1, 0), 100 + i);
    end
    mem_ready = 1;
    cych(fetch_exp(1, 1), 1);
    e = fetch_exp(2, 0);
    if (k == K_NOP) e.done = 1;
    cych(e, 2);
    if (k == K_NOP || k == K_HALT || k == K_ILL) return;
    for (int t = 3; t <= last; t++) begin
      if (drop_run && t == 3) run = 0;
      if (t == abort_at) begin
        clear = 0;
        cych('0, t);
        clear = 1;
        return;
      end
      cych(exec_exp(w, t), t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    outs_t e;
    clear = 0; run = 0; mem_ready = 1; ir = 32'h0;
    tick();

    run = 1;
    step('0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_pcout", 32'(PCout), 0);
    tick();
    clear = 1; run = 0;
    cur_tag = "idle";
    cyc('0); cyc('0);
    run = 1;
    cyc('0);

    run_instr(32'h112B0000, 0, 0, 0, "add");
    run_instr(32'h18918000, 3, 0, 0, "sub_wait");
    run_instr(32'h79A00000, 0, 0, 0, "mul");
    run_instr(32'h82B00000, 2, 0, 0, "div");
    run_instr(32'h53C00000, 0, 0, 0, "addi");
    run_instr(32'h94D00000, 0, 0, 0, "not");
    run_instr(32'h20788000, 0, 0, 0, "and_r0");
    run_instr(32'hD0000000, 0, 0, 0, "nop");
`ifndef ILLEGAL_TRAP_EN
    run_instr(32'hF8000000, 0, 0, 0, "undef_nop");
`endif
    run_instr(32'h45E68000, 1, 1, 0, "ror_stop");
    cur_tag = "stop_idle";
    cyc('0); cyc('0);

    run = 1;
    cyc('0);
    run_instr(32'h112B0000, 0, 0, 4, "add_clr");
    cur_tag = "clr_idle";
    cyc('0);

    run_instr(32'hD8000000, 0, 0, 0, "halt");
    cur_tag = "halted";
    for (int i = 0; i < 10; i++) begin
      run = (i % 2 == 1);
      e = '0;
      e.halt = 1;
      step(e);
      if (i == 0) chk("halt_first", 32'(halted), 1);
      tick();
    end
    clear = 0;
    cur_tag = "halt_clear";
    cyc('0);
    clear = 1; run = 0;
    step('0);
    chk("halt_released", 32'(halted), 0);
    tick();
    cyc('0);

`ifdef ILLEGAL_TRAP_EN
    run = 1;
    cyc('0);
    run_instr(32'hF8000000, 0, 0, 0, "undef_trap");
    cur_tag = "trap";
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.halt = 1;
      e.ill = 1;
      step(e);
      if (i == 0) chk("trap_illegal_op", 32'(illegal_op), 1);
      tick();
    end
    clear = 0;
    cyc('0);
    clear = 1; run = 0;
    cyc('0);
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
